// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle fetch/decode/execute/memory sequencer for the 16-bit instruction datapath.
// Outputs are combinational from state and inputs; only the state, timeout counter and trap flags are registered.
module cpu_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic [2:0] opcode2,
    input  logic       zero_flag,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [2:0] alu_op,
    output logic       alu_src_imm,
    output logic       reg_we,
    output logic       wb_sel,
    output logic       halted,
    output logic       illegal,
    output logic       bus_error
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, HALT} state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             illegal_q, illegal_d;
    logic             bus_error_q, bus_error_d;
    logic             is_alu;

    assign is_alu = opcode >= 4'h1 && opcode <= 4'h8;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            tmo_q       <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Reset gates every output so an in-flight request drops without waiting for an edge.
    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        tmo_d       = tmo_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        alu_op      = 3'd0;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;
        bus_error   = 1'b0;
        if (!reset) begin
            illegal   = illegal_q;
            bus_error = bus_error_q;
            case (state_q)
                FETCH: begin
                    mem_req = 1'b1;
                    ir_load = mem_ack;
                    pc_inc  = mem_ack;
                    state_d = mem_ack ? DECODE : FETCH;
                end
                DECODE: begin
                    if (opcode == 4'hB || opcode == 4'hF) begin
                        state_d   = HALT;
                        illegal_d = 1'b1;
                    end else if (opcode == 4'hE)
                        state_d = (opcode2 == 3'b000) ? HALT : FETCH;
                    else if (opcode == 4'h9 || opcode == 4'hA)
                        state_d = MEM;
                    else
                        state_d = (opcode == 4'h0) ? FETCH : EXEC;
                end
                EXEC: begin
                    // Opcodes 1..8 map linearly onto ADD..PASS_B.
                    alu_op      = is_alu ? 3'(opcode - 4'd1) : 3'd0;
                    alu_src_imm = opcode == 4'h8;
                    reg_we      = is_alu;
                    pc_load     = opcode == 4'hC || (opcode == 4'hD && zero_flag);
                    state_d     = FETCH;
                end
                MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = opcode == 4'hA;
                    reg_we   = mem_ack && opcode != 4'hA;
                    wb_sel   = mem_ack && opcode != 4'hA;
                    state_d  = mem_ack ? FETCH : MEM;
                end
                HALT:    halted = 1'b1;
                default: state_d = FETCH;
            endcase
            // An ack in the last allowed cycle still completes the access.
            if (mem_req && !mem_ack && tmo_q == TMO_LAST) begin
                state_d     = HALT;
                bus_error_d = 1'b1;
            end
            tmo_d = (state_d != state_q || mem_ack) ? '0 : mem_req ? tmo_q + TMO_W'(1) : tmo_q;
        end
    end
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: builds expected per-cycle traces from instruction-level rules, then replays them against the DUT.
module tb_cpu_control_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic [2:0] opcode2 = 3'b0;
    logic       zero_flag = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load;
    logic [2:0] alu_op;
    logic       alu_src_imm, reg_we, wb_sel, halted, illegal, bus_error;

    cpu_control_fsm #(.MEM_TIMEOUT(15), .TMO_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .opcode2(opcode2), .zero_flag(zero_flag),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .alu_op(alu_op),
        .alu_src_imm(alu_src_imm), .reg_we(reg_we), .wb_sel(wb_sel), .halted(halted),
        .illegal(illegal), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [3:0]  op;
        logic [2:0]  op2;
        logic        zf;
        logic        ack;
        logic [14:0] exp;
    } step_t;

    step_t      q[$];
    logic       m_ill = 1'b0, m_berr = 1'b0;
    logic [3:0] cur_op = 4'h0;
    logic [2:0] cur_op2 = 3'b0;
    logic       cur_zf = 1'b1;
    int         n_chk = 0, n_fail = 0;

    // {req, we, addr_sel, ir_load, pc_inc, pc_load, alu_op, imm, reg_we, wb_sel, halted, illegal, bus_error}
    function automatic logic [14:0] ov(input logic req, we, as, irl, pinc, pld, input logic [2:0] aop,
                                       input logic imm, rwe, wb, h);
        return {req, we, as, irl, pinc, pld, aop, imm, rwe, wb, h, m_ill, m_berr};
    endfunction

    task automatic push(input logic rst, input logic ack, input logic [14:0] e);
        step_t s;
        s.rst = rst; s.op = cur_op; s.op2 = cur_op2; s.zf = cur_zf; s.ack = ack; s.exp = e;
        q.push_back(s);
    endtask

    task automatic do_reset();
        m_ill = 1'b0;
        m_berr = 1'b0;
        push(1'b1, 1'b1, 15'd0);
    endtask

    task automatic fetch(input int waits);
        repeat (waits) push(1'b0, 1'b0, ov(1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
        push(1'b0, 1'b1, ov(1, 0, 0, 1, 1, 0, 3'd0, 0, 0, 0, 0));
    endtask

    task automatic halt_cycles(input int n);
        repeat (n) push(1'b0, 1'b1, ov(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1));
    endtask

    task automatic instr(input logic [3:0] op, input logic [2:0] op2, input logic zf, input int fw, input int mw);
        logic [2:0] aop;
        cur_op = op; cur_op2 = op2; cur_zf = zf;
        fetch(fw);
        push(1'b0, 1'b1, ov(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
        if (op >= 4'h1 && op <= 4'h8) begin
            aop = (op <= 4'h5) ? 3'(op - 4'd1) : (op == 4'h6) ? 3'd5 : (op == 4'h7) ? 3'd6 : 3'd7;
            push(1'b0, 1'b1, ov(0, 0, 0, 0, 0, 0, aop, op == 4'h8, 1, 0, 0));
        end else if (op == 4'hC || op == 4'hD)
            push(1'b0, 1'b1, ov(0, 0, 0, 0, 0, op == 4'hC || zf, 3'd0, 0, 0, 0, 0));
        else if (op == 4'h9 || op == 4'hA) begin
            repeat (mw) push(1'b0, 1'b0, ov(1, op == 4'hA, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0));
            push(1'b0, 1'b1, ov(1, op == 4'hA, 1, 0, 0, 0, 3'd0, 0, op == 4'h9, op == 4'h9, 0));
        end else if (op == 4'hB || op == 4'hF || (op == 4'hE && op2 == 3'b000)) begin
            if (op != 4'hE) m_ill = 1'b1;
            halt_cycles(3);
        end
    endtask

    task automatic pin(input string name, input logic [14:0] got, input logic [14:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: model %h expected %h", name, got, want);
        end
    endtask

    initial begin
        int mark;
        step_t s;
        logic [14:0] got;
        do_reset();
        instr(4'h1, 3'b0, 1'b1, 0, 0);
        pin("model_add_fetch", q[1].exp, 15'h4C00);
        pin("model_add_decode", q[2].exp, 15'h0000);
        pin("model_add_exec", q[3].exp, 15'h0010);
        instr(4'h0, 3'b0, 1'b1, 0, 0);
        instr(4'h2, 3'b0, 1'b0, 1, 0);
        instr(4'h3, 3'b0, 1'b1, 0, 0);
        instr(4'h4, 3'b0, 1'b1, 0, 0);
        instr(4'h5, 3'b0, 1'b1, 0, 0);
        instr(4'h6, 3'b0, 1'b1, 0, 0);
        instr(4'h7, 3'b0, 1'b1, 0, 0);
        instr(4'h8, 3'b0, 1'b1, 0, 0);
        pin("model_li_exec", q[q.size()-1].exp, 15'h01F0);
        mark = q.size();
        instr(4'h9, 3'b0, 1'b1, 1, 3);
        pin("model_ld_ack", q[mark+6].exp, 15'h5018);
        instr(4'hA, 3'b0, 1'b1, 0, 3);
        instr(4'hC, 3'b0, 1'b0, 0, 0);
        mark = q.size();
        instr(4'hD, 3'b0, 1'b1, 0, 0);
        pin("model_bz_taken", q[mark+2].exp, 15'h0200);
        instr(4'hD, 3'b0, 1'b0, 0, 0);
        instr(4'hE, 3'b011, 1'b1, 0, 0);
        instr(4'h1, 3'b0, 1'b1, 0, 0);
        instr(4'hE, 3'b000, 1'b1, 0, 0);
        do_reset();
        instr(4'hF, 3'b0, 1'b1, 0, 0);
        do_reset();
        instr(4'hB, 3'b101, 1'b1, 2, 0);
        do_reset();
        cur_op = 4'h1;
        repeat (15) push(1'b0, 1'b0, ov(1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
        m_berr = 1'b1;
        halt_cycles(3);
        do_reset();
        instr(4'h2, 3'b0, 1'b1, 14, 0);
        instr(4'h9, 3'b0, 1'b1, 0, 14);
        cur_op = 4'hA;
        fetch(0);
        push(1'b0, 1'b1, ov(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
        repeat (2) push(1'b0, 1'b0, ov(1, 1, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0));
        do_reset();
        instr(4'h1, 3'b0, 1'b1, 0, 0);
        for (int i = 0; q.size() > 0; i++) begin
            s = q.pop_front();
            @(negedge clk);
            reset = s.rst; opcode = s.op; opcode2 = s.op2; zero_flag = s.zf; mem_ack = s.ack;
            #1;
            got = {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, alu_op, alu_src_imm,
                   reg_we, wb_sel, halted, illegal, bus_error};
            n_chk++;
            if (got !== s.exp) begin
                n_fail++;
                $display("FAIL step %0d (op %h rst %b ack %b): got %b want %b", i, s.op, s.rst, s.ack, got, s.exp);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
- Multi-cycle control sequencer for the 8-bit computer's 16-bit instruction datapath.
- Uses the decoded opcode fields from the instruction register and a one-request memory handshake to sequence fetch, decode, execute, memory access and writeback.
- Drives IR load, PC update, ALU select, register-file write and memory strobes.
- Traps on illegal opcodes and on memory timeouts.

Parameters:
- MEM_TIMEOUT, 15: cycles mem_req may stay high without mem_ack before a bus error (legal range 1..255).
- TMO_W, 8: width of the timeout counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- opcode  input  4  instruction[15:12] from the decoder (IR-based)
- opcode2  input  3  instruction[11:9], sub-opcode for opcode 0xE
- zero_flag  input  1  registered ALU zero flag
- mem_ack  input  1  memory completion; read data valid in the same cycle
- mem_req  output  1  memory request, held until ack or timeout
- mem_we  output  1  write strobe, valid only while mem_req=1
- addr_sel  output  1  0 = PC drives address, 1 = register Rs1 drives address
- ir_load  output  1  capture memory data into IR
- pc_inc  output  1  PC <= PC+1
- pc_load  output  1  PC <= constant[7:0]
- alu_op  output  3  ALU function: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 PASS_B
- alu_src_imm  output  1  ALU B operand = constant (else Rs2)
- reg_we  output  1  register-file write enable for Rm
- wb_sel  output  1  0 = ALU result, 1 = memory data
- halted  output  1  core stopped (HALT, illegal opcode or bus error)
- illegal  output  1  sticky: illegal opcode trap
- bus_error  output  1  sticky: memory timeout trap

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, HALT. Encoding is free.
- Reset (async, active-high): state=FETCH, timeout counter=0, illegal=0, bus_error=0.
  - While reset is asserted all outputs are 0, including mem_req.
  - Reset mid-access abandons the request immediately.
- All outputs are combinational from state, opcode, opcode2, zero_flag and mem_ack. No other registered outputs.
- FETCH:
  - mem_req=1, addr_sel=0, mem_we=0.
  - On mem_ack: ir_load=1 and pc_inc=1 in that same cycle, then go to DECODE.
- DECODE: one cycle, no strobes. Routing by opcode:
  - 0x0 NOP -> FETCH.
  - 0x1..0x7 ALU ops, 0x8 LI, 0xC JMP, 0xD BZ -> EXEC.
  - 0x9 LD, 0xA ST -> MEM.
  - 0xE with opcode2=000 (HALT) -> HALT.
  - 0xE with any other opcode2 -> FETCH (treated as NOP).
  - 0xB, 0xF -> HALT and set illegal.
- EXEC (one cycle, always returns to FETCH):
  - 0x1..0x5: alu_op = opcode-1, alu_src_imm=0, reg_we=1, wb_sel=0.
  - 0x6 SHL / 0x7 SHR: alu_op = 5 / 6; the shift amount comes from shiftamt in the datapath; reg_we=1.
  - 0x8 LI: alu_op=7, alu_src_imm=1, reg_we=1.
  - 0xC JMP: pc_load=1.
  - 0xD BZ: pc_load = zero_flag.
- MEM:
  - mem_req=1, addr_sel=1.
  - LD: mem_we=0; on mem_ack, reg_we=1 and wb_sel=1.
  - ST: mem_we=1 for the whole request.
  - On mem_ack -> FETCH.
- Timeout:
  - The counter increments on every cycle with mem_req=1 and mem_ack=0, and clears on ack or on any state change.
  - The cycle in which the counter equals MEM_TIMEOUT-1 with no ack is the last request cycle. Next state is HALT with bus_error set.
  - Ack in that same cycle wins; no error is raised.
- HALT: absorbing state; halted=1 and all strobes 0. Only reset exits.
- mem_ack while mem_req=0 is ignored.
- pc_inc and pc_load are never asserted in the same cycle.
- Latencies with zero-wait memory:
  - ALU, LI, JMP, BZ: 3 cycles.
  - LD, ST: 3 cycles.
  - NOP: 2 cycles.
  - Each memory wait cycle adds 1 cycle.

Test Plan:
- Reset, then fetch ADD (opcode 0x1) with ack in the same cycle -> cycle 0 ir_load=pc_inc=1; cycle 1 DECODE with no strobes; cycle 2 reg_we=1, alu_op=0; cycle 3 mem_req=1 (FETCH).
- LD (0x9) with ack delayed 3 cycles -> mem_req=1 and addr_sel=1 for 4 cycles; reg_we=1 and wb_sel=1 only in the ack cycle. ST (0xA) under the same timing -> mem_we=1 on all 4 cycles, reg_we=0 throughout.
- BZ (0xD) with zero_flag=1 -> pc_load=1 in EXEC. BZ with zero_flag=0 -> pc_load=0. In both cases pc_inc=0 in EXEC.
- Fetch returns no ack, MEM_TIMEOUT=15 -> mem_req high for exactly 15 cycles, then halted=1 and bus_error=1. Repeat with ack on the 15th cycle -> no error, normal DECODE.
- Opcode 0xF -> halted=1 and illegal=1 after DECODE. Opcode 0xE with opcode2=000 -> halted=1, illegal=0. Opcode 0xE with opcode2=011 -> returns to FETCH.
- Assert reset while MEM is waiting on a store -> mem_req and mem_we drop to 0 asynchronously, before the next edge. After release, FETCH with illegal=0 and bus_error=0.
